grey_to_binary_converter: RTL and testbench
===========================================

# grey_to_binary_converter

Registered 4-bit Gray-code to binary converter with a single-cycle valid handshake and Gray-sequence integrity checking. It sits between a Gray-coded source, such as a position encoder or a CDC pointer, and binary consumer logic. Each accepted Gray word is decoded to binary one clock later. The block also flags successive accepted words that differ in more than one bit and counts those violations.

## Interface

- No parameters; the width is fixed at 4 bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  qualifies `g3..g0` in the current cycle.
- `g3`  input  1  Gray-code MSB.
- `g2`  input  1  Gray-code bit 2.
- `g1`  input  1  Gray-code bit 1.
- `g0`  input  1  Gray-code LSB.
- `b3`  output  1  binary MSB (registered).
- `b2`  output  1  binary bit 2 (registered).
- `b1`  output  1  binary bit 1 (registered).
- `b0`  output  1  binary LSB (registered).
- `out_valid`  output  1  one-cycle pulse; `b3..b0` were updated on this edge.
- `gray_err`  output  1  one-cycle pulse accompanying `out_valid`; the accepted word violated the Gray sequence.
- `err_cnt`  output  8  saturating count of `gray_err` events since reset.

## Operation

- **Decode.** The decoded value is b3=g3, b2=g3^g2, b1=g3^g2^g1, b0=g3^g2^g1^g0, using an XOR prefix from the MSB down.
- **Accept.** On a rising `clk` with `in_valid`=1:
  - register the decoded bits into `b3..b0`;
  - set `out_valid`=1;
  - store `g3..g0` as the previous word;
  - set the internal `have_prev` flag.
- **Hold.** With `in_valid`=0:
  - `b3..b0` hold their value;
  - `out_valid`=0;
  - `gray_err`=0;
  - the previous word is unchanged.
- **Integrity check.** Applies on an accepted cycle with `have_prev`=1.
  - Compute the Hamming distance between the incoming `g3..g0` and the previous word.
  - A distance of 2 or more sets `gray_err`=1 for that cycle.
  - A distance of 0 (repeat) or 1 is legal.
- **First word.** The first accepted word after reset has `have_prev`=0 and never raises `gray_err`.
- **Error counter.** `err_cnt` increments by 1 on every `gray_err` pulse and saturates at 255 with no wrap.
- **No stall.** There is no backpressure: every `in_valid` cycle is accepted.

## Timing

- **Reset.** While `rst_n`=0, asynchronously and immediately:
  - `b3..b0`=0000;
  - `out_valid`=0;
  - `gray_err`=0;
  - `err_cnt`=0;
  - `have_prev`=0;
  - previous word=0000.
- **Reset release.** Deassertion is sampled at the next rising edge. The first edge with `rst_n`=1 and `in_valid`=1 is the first accept.
- **Latency.** Exactly 1 cycle from inputs sampled with `in_valid` to `b3..b0`/`out_valid`/`gray_err` visible.
- **Throughput.** One word per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`.
- **Error timing.** `gray_err` is asserted in the same cycle as the `out_valid` of the offending word. `err_cnt` reflects that error in the same cycle as `gray_err`, since both are registered on the same edge.
- **Reset mid-stream.** All state clears. The next accepted word is treated as a first word, so it raises no error.
- **Paths.** Outputs are fully registered, with no combinational path from any input to any output.

## Test plan

- **Reset values.** Assert `rst_n`=0 mid-operation -> `b3..b0`=0000, `out_valid`=0, `gray_err`=0 and `err_cnt`=0 immediately, with no clock edge needed.
- **Directed decode.** Apply `in_valid` pulses with g=0011, 0111, 1011 and 0011 on separate cycles. Required on the edge after each:
  - b=0010, 0101, 1101 and 0010;
  - `out_valid`=1 each time.
- **Exhaustive sequence.** Feed the 16 Gray codes in reflected order 0000, 0001, 0011 … 1000 back-to-back. Required:
  - b counts 0000 through 1111 with 1-cycle latency;
  - `gray_err` never asserts;
  - `err_cnt`=0.
- **Hold.** Accept g=1000 (b=1111), then hold `in_valid`=0 for 5 cycles while toggling g. Required: b stays 1111 and `out_valid`=0.
- **Integrity.**
  - After reset, accept 0011 -> no error.
  - Accept 0011 again -> no error (repeat).
  - Accept 1011 -> no error (distance 1).
  - Accept 0111 -> `gray_err`=1 (distance 2) and `err_cnt`=1.
- **Saturation.** Alternate 0000/1111 for 300 accepted cycles. Required: `err_cnt` reaches 255 and holds there, while `gray_err` keeps pulsing on each violating word.

Source files
------------

// File: rtl/grey_to_binary_converter.sv
// Registered 4-bit Gray-to-binary decoder with a valid handshake.
// Consecutive accepted words that differ in more than one bit are flagged
// on gray_err and counted in a saturating 8-bit err_cnt.
module grey_to_binary_converter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       g3,
  input  logic       g2,
  input  logic       g1,
  input  logic       g0,
  output logic       b3,
  output logic       b2,
  output logic       b1,
  output logic       b0,
  output logic       out_valid,
  output logic       gray_err,
  output logic [7:0] err_cnt
);

  // Gray word to binary: XOR prefix running from the MSB down.
  function automatic logic [3:0] gray_decode(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when two words differ in two or more bit positions.
  function automatic logic multi_bit_change(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] diff;
    diff = a ^ b;
    // Clearing the lowest set bit leaves something only if >= 2 bits were set.
    return (diff & (diff - 4'd1)) != 4'd0;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [3:0] gray_p0;
  logic [3:0] bin_p0;
  logic       viol_p0;
  logic [3:0] prev_p1;
  logic       have_prev_p1;

  // Stage 0: decode and integrity check on the incoming word.
  always_comb begin
    gray_p0 = {g3, g2, g1, g0};
    bin_p0  = gray_decode(gray_p0);
    viol_p0 = have_prev_p1 && multi_bit_change(gray_p0, prev_p1);
  end

  // Stage 1: register decoded word, flags, history and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {b3, b2, b1, b0} <= 4'b0000;
      out_valid        <= 1'b0;
      gray_err         <= 1'b0;
      err_cnt          <= 8'd0;
      prev_p1          <= 4'b0000;
      have_prev_p1     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      gray_err  <= in_valid && viol_p0;
      if (in_valid) begin
        {b3, b2, b1, b0} <= bin_p0;
        prev_p1          <= gray_p0;
        have_prev_p1     <= 1'b1;
        if (viol_p0) begin
          err_cnt <= sat_inc(err_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_grey_to_binary_converter.sv
// Randomised and directed bench for grey_to_binary_converter with an
// arithmetic reference model and per-cycle output comparison.
module tb_grey_to_binary_converter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] gin;
  logic       b3, b2, b1, b0;
  logic       out_valid, gray_err;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  grey_to_binary_converter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .g3(gin[3]), .g2(gin[2]), .g1(gin[1]), .g0(gin[0]),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0),
    .out_valid(out_valid), .gray_err(gray_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: binary n is the value whose Gray code n^(n>>1) equals g.
  function automatic logic [3:0] ref_decode(input logic [3:0] g);
    logic [3:0] r;
    r = 4'd0;
    for (int n = 0; n < 16; n++) begin
      if (((n ^ (n >> 1)) & 15) == int'(g)) r = 4'(n);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [3:0] m_b, m_prev;
  logic       m_ov, m_err, m_hp;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b <= 4'd0; m_prev <= 4'd0; m_ov <= 1'b0; m_err <= 1'b0;
      m_hp <= 1'b0; m_cnt <= 0;
    end else begin
      m_ov  <= in_valid;
      m_err <= in_valid && m_hp && ($countones(gin ^ m_prev) >= 2);
      if (in_valid) begin
        m_b    <= ref_decode(gin);
        m_prev <= gin;
        m_hp   <= 1'b1;
        if (m_hp && ($countones(gin ^ m_prev) >= 2))
          m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end
  end

  // Compare DUT against model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("outputs", {18'd0, b3, b2, b1, b0, out_valid, gray_err, err_cnt},
            {18'd0, m_b, m_ov, m_err, m_cnt[7:0]});
    end
  end

  // Drive one cycle of inputs (called at a falling edge, returns at the next).
  task automatic step(input logic v, input logic [3:0] g);
    in_valid = v;
    gin      = g;
    @(negedge clk);
  endtask

  // Assert reset mid-cycle and check outputs clear with no clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_b",   {28'd0, b3, b2, b1, b0}, 32'd0);
    check("rst_ov",  {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, gray_err}, 32'd0);
    check("rst_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    rst_n = 1'b0; in_valid = 1'b0; gin = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed decode
    step(1'b1, 4'b0011); check("dec0011", {28'd0, b3, b2, b1, b0}, 32'b0010);
    check("dec_ov", {31'd0, out_valid}, 32'd1);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0111); check("dec0111", {28'd0, b3, b2, b1, b0}, 32'b0101);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b1011); check("dec1011", {28'd0, b3, b2, b1, b0}, 32'b1101);
    check("dec_err", {31'd0, gray_err}, 32'd1);
    step(1'b0, 4'b0000);
    check("dec_idle_ov", {31'd0, out_valid}, 32'd0);
    step(1'b1, 4'b0011); check("dec0011b", {28'd0, b3, b2, b1, b0}, 32'b0010);

    // Reset in the middle of activity (err_cnt is 1 here)
    in_valid = 1'b1; gin = 4'b1100;
    do_reset();

    // Exhaustive reflected Gray sequence, back-to-back
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i ^ (i >> 1)));
      check("seq_b", {28'd0, b3, b2, b1, b0}, 32'(i));
      check("seq_err", {31'd0, gray_err}, 32'd0);
    end
    check("seq_cnt", {24'd0, err_cnt}, 32'd0);

    // Hold: last word 1000 -> b=1111
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)));
      check("hold_b", {28'd0, b3, b2, b1, b0}, 32'hF);
      check("hold_ov", {31'd0, out_valid}, 32'd0);
    end

    // Integrity
    do_reset();
    step(1'b1, 4'b0011); check("int_first", {31'd0, gray_err}, 32'd0);
    step(1'b1, 4'b0011); check("int_repeat", {31'd0, gray_err}, 32'd0);
    step(1'b1, 4'b1011); check("int_dist1", {31'd0, gray_err}, 32'd0);
    step(1'b1, 4'b0111); check("int_dist2", {31'd0, gray_err}, 32'd1);
    check("int_cnt", {24'd0, err_cnt}, 32'd1);

    // Randomised traffic, biased toward legal single-bit steps
    g = 4'b0111;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) g = g ^ (4'd1 << $urandom_range(0, 3));
      else g = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), g);
    end

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2) ? 4'hF : 4'h0);
      if (i == 256) check("sat_mid", {24'd0, err_cnt}, 32'd255);
    end
    check("sat_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_err", {31'd0, gray_err}, 32'd1);
    step(1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
